// File: rtl/usb_pkg.sv
// Shared USB host-sequencer definitions: PIDs, FSM state codes and counter widths.
// Pure declarations; no logic, no latency, no flow control.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam int RETRY_W = 4;
  localparam int TMO_W   = 8;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_TOKEN        = 3'd1;
  localparam logic [2:0] ST_OUT_DATA     = 3'd2;
  localparam logic [2:0] ST_OUT_WAIT_HS  = 3'd3;
  localparam logic [2:0] ST_IN_WAIT_DATA = 3'd4;
  localparam logic [2:0] ST_IN_HS        = 3'd5;
  localparam logic [2:0] ST_FINISH       = 3'd6;

  function automatic logic is_wait_state(input logic [2:0] st);
    return (st == ST_OUT_WAIT_HS) || (st == ST_IN_WAIT_DATA);
  endfunction

endpackage

// File: rtl/txn_timeout_timer.sv
// Wait-state watchdog: expired is combinational on the count, high in the TIMEOUT_CYCLES-th enabled cycle after clr.
// No backpressure; clr wins over en, and the count parks at its last value.
module txn_timeout_timer
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/usb_txn_sequencer.sv
// Host USB transaction FSM: token, DATA0/handshake via encoder, decoder waits with timeout and bounded retry.
// enc_req is registered one cycle after the deciding event; the encoder throttles progress through enc_done.
module usb_txn_sequencer
  import usb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 txn_start,
  input  logic                 txn_is_in,
  output logic                 busy,
  output logic                 txn_done,
  output logic                 txn_ok,
  output logic [RETRY_W-1:0]   txn_retries,
  output logic                 enc_req,
  output logic [3:0]           enc_pid,
  input  logic                 enc_done,
  input  logic                 dec_pkt_avail,
  input  logic                 dec_valid,
  input  logic [3:0]           dec_pid
);

  logic [2:0]         state, state_nxt;
  logic               is_in_q;
  logic               ok_pend, ok_pend_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt, retry_inc;
  logic               at_limit;
  logic               req_nxt;
  logic [3:0]         pid_nxt;
  logic               fin_ok;
  logic               tmr_clr, tmr_expired;

  assign retry_inc = retry_cnt + 1'b1;
  assign at_limit  = (retry_inc == RETRY_W'(MAX_RETRY));

  always_comb begin
    state_nxt   = state;
    req_nxt     = 1'b0;
    pid_nxt     = enc_pid;
    tmr_clr     = 1'b0;
    fin_ok      = 1'b0;
    retry_nxt   = retry_cnt;
    ok_pend_nxt = ok_pend;
    case (state)
      ST_IDLE: if (txn_start) begin
        state_nxt   = ST_TOKEN;
        req_nxt     = 1'b1;
        pid_nxt     = txn_is_in ? PID_IN : PID_OUT;
        retry_nxt   = '0;
        ok_pend_nxt = 1'b0;
      end
      ST_TOKEN: if (enc_done) begin
        if (is_in_q) begin
          state_nxt = ST_IN_WAIT_DATA;
          tmr_clr   = 1'b1;
        end else begin
          state_nxt = ST_OUT_DATA;
          req_nxt   = 1'b1;
          pid_nxt   = PID_DATA0;
        end
      end
      ST_OUT_DATA: if (enc_done) begin
        state_nxt = ST_OUT_WAIT_HS;
        tmr_clr   = 1'b1;
      end
      ST_OUT_WAIT_HS: begin
        // a packet in the expiry cycle is judged on its own merits, not as a timeout
        if (dec_pkt_avail && dec_valid && (dec_pid == PID_ACK)) begin
          state_nxt = ST_FINISH;
          fin_ok    = 1'b1;
        end else if (dec_pkt_avail || tmr_expired) begin
          retry_nxt = retry_inc;
          if (at_limit) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt = ST_OUT_DATA;
            req_nxt   = 1'b1;
            pid_nxt   = PID_DATA0;
          end
        end
      end
      ST_IN_WAIT_DATA: begin
        if (dec_pkt_avail && dec_valid && (dec_pid == PID_DATA0)) begin
          state_nxt   = ST_IN_HS;
          req_nxt     = 1'b1;
          pid_nxt     = PID_ACK;
          ok_pend_nxt = 1'b1;
        end else if (dec_pkt_avail) begin
          retry_nxt = retry_inc;
          if (at_limit) begin
            state_nxt = ST_FINISH;
          end else begin
            state_nxt = ST_IN_HS;
            req_nxt   = 1'b1;
            pid_nxt   = PID_NAK;
          end
        end else if (tmr_expired) begin
          retry_nxt = retry_inc;
          if (at_limit) begin
            state_nxt = ST_FINISH;
          end else begin
            tmr_clr = 1'b1;
          end
        end
      end
      ST_IN_HS: if (enc_done) begin
        if (ok_pend) begin
          state_nxt = ST_FINISH;
          fin_ok    = 1'b1;
        end else begin
          state_nxt = ST_IN_WAIT_DATA;
          tmr_clr   = 1'b1;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= ST_IDLE;
      is_in_q     <= 1'b0;
      ok_pend     <= 1'b0;
      retry_cnt   <= '0;
      enc_req     <= 1'b0;
      enc_pid     <= 4'd0;
      txn_ok      <= 1'b0;
      txn_retries <= '0;
    end else begin
      state     <= state_nxt;
      ok_pend   <= ok_pend_nxt;
      retry_cnt <= retry_nxt;
      enc_req   <= req_nxt;
      enc_pid   <= pid_nxt;
      if ((state == ST_IDLE) && txn_start) begin
        is_in_q     <= txn_is_in;
        txn_ok      <= 1'b0;
        txn_retries <= '0;
      end
      if ((state_nxt == ST_FINISH) && (state != ST_FINISH)) begin
        txn_ok      <= fin_ok;
        txn_retries <= retry_nxt;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign txn_done = (state == ST_FINISH);

  txn_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (tmr_clr),
    .en      (is_wait_state(state)),
    .expired (tmr_expired)
  );

endmodule
